// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - instruction-field handshake bundle for instr_encoder_loader
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;

  modport master (
    output in_valid, op_sel, rs, rt, rd, shamt, imm, target,
    input  in_ready
  );

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, shamt, imm, target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - MIPS instruction encoder writing consecutive words into instruction memory
// Optional feature macro: ENC_BRANCH_REL_EN (BEQ/BNE imm taken as absolute word address).
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  instr_encoder_loader_if.slave i_bus,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [ADDR_W:0]       o_word_count,
  output logic                  o_done,
  output logic                  o_err_illegal,
  output logic                  o_err_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [31:0]       STOP_WORD = 32'hFC00_0000;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W:0]     r_word_count;
  logic                r_done;
  logic                r_err_illegal;
  logic                r_err_overflow;

  logic [31:0] w_word;
  logic [15:0] w_branch_off;
  logic        w_legal;
  logic        w_stop;
  logic        w_accept;

  assign w_legal  = (i_bus.op_sel <= 5'd27);
  assign w_stop   = (i_bus.op_sel == 5'd27);
  assign w_accept = r_in_ready && i_bus.in_valid;

  always_comb begin
    w_branch_off = i_bus.imm;
`ifdef ENC_BRANCH_REL_EN
    w_branch_off = i_bus.imm - (16'(r_wr_addr) + 16'd1);
`endif
  end

  // Shift-by-immediate zeroes rs; register-sourced ops zero shamt; JR keeps only rs.
  always_comb begin
    w_word = 32'd0;
    case (i_bus.op_sel)
      5'd0:  w_word = {11'd0, i_bus.rt, i_bus.rd, i_bus.shamt, 6'd0};
      5'd1:  w_word = {11'd0, i_bus.rt, i_bus.rd, i_bus.shamt, 6'd2};
      5'd2:  w_word = {11'd0, i_bus.rt, i_bus.rd, i_bus.shamt, 6'd3};
      5'd3:  w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd4};
      5'd4:  w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd6};
      5'd5:  w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd7};
      5'd6:  w_word = {6'd0, i_bus.rs, 15'd0, 6'd8};
      5'd7:  w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd32};
      5'd8:  w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd33};
      5'd9:  w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd34};
      5'd10: w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd35};
      5'd11: w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd36};
      5'd12: w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd37};
      5'd13: w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd38};
      5'd14: w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd39};
      5'd15: w_word = {6'd0, i_bus.rs, i_bus.rt, i_bus.rd, 5'd0, 6'd42};
      5'd16: w_word = {6'd4,  i_bus.rs, i_bus.rt, w_branch_off};
      5'd17: w_word = {6'd5,  i_bus.rs, i_bus.rt, w_branch_off};
      5'd18: w_word = {6'd8,  i_bus.rs, i_bus.rt, i_bus.imm};
      5'd19: w_word = {6'd9,  i_bus.rs, i_bus.rt, i_bus.imm};
      5'd20: w_word = {6'd12, i_bus.rs, i_bus.rt, i_bus.imm};
      5'd21: w_word = {6'd13, i_bus.rs, i_bus.rt, i_bus.imm};
      5'd22: w_word = {6'd14, i_bus.rs, i_bus.rt, i_bus.imm};
      5'd23: w_word = {6'd35, i_bus.rs, i_bus.rt, i_bus.imm};
      5'd24: w_word = {6'd43, i_bus.rs, i_bus.rt, i_bus.imm};
      5'd25: w_word = {6'd2, i_bus.target};
      5'd26: w_word = {6'd3, i_bus.target};
      5'd27: w_word = STOP_WORD;
      default: w_word = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= 32'd0;
      r_wr_addr      <= '0;
      r_word_count   <= '0;
      r_done         <= 1'b0;
      r_err_illegal  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state        <= S_RUN;
            r_in_ready     <= 1'b1;
            r_wr_addr      <= '0;
            r_word_count   <= '0;
            r_done         <= 1'b0;
            r_err_illegal  <= 1'b0;
            r_err_overflow <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (!w_legal) begin
              r_err_illegal <= 1'b1;
            end else begin
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_wr_addr;
              r_mem_wdata  <= w_word;
              r_word_count <= r_word_count + CNT_ONE;
              r_wr_addr    <= r_wr_addr + ADDR_ONE;
              // Last slot written by anything other than STOP means the program did not fit.
              if (w_stop || (r_wr_addr == ADDR_LAST)) begin
                r_state    <= S_DONE;
                r_in_ready <= 1'b0;
                r_done     <= 1'b1;
                if (!w_stop) r_err_overflow <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign i_bus.in_ready = r_in_ready;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_word_count   = r_word_count;
  assign o_done         = r_done;
  assign o_err_illegal  = r_err_illegal;
  assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - self-checking bench for instr_encoder_loader (ADDR_W=8 and ADDR_W=2 instances)
module tb_instr_encoder_loader;

  localparam int FUNC [0:15] = '{0, 2, 3, 4, 6, 7, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42};
  localparam int OPC  [16:26] = '{4, 5, 8, 9, 12, 13, 14, 35, 43, 2, 3};
  localparam int DEPTH [0:1] = '{256, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, st, v;
  logic [4:0]  op, rs, rt, rd, sh;
  logic [15:0] imm;
  logic [25:0] tg;

  instr_encoder_loader_if if8 ();
  instr_encoder_loader_if if2 ();

  assign if8.in_valid = v;  assign if2.in_valid = v;
  assign if8.op_sel   = op; assign if2.op_sel   = op;
  assign if8.rs       = rs; assign if2.rs       = rs;
  assign if8.rt       = rt; assign if2.rt       = rt;
  assign if8.rd       = rd; assign if2.rd       = rd;
  assign if8.shamt    = sh; assign if2.shamt    = sh;
  assign if8.imm      = imm; assign if2.imm     = imm;
  assign if8.target   = tg; assign if2.target   = tg;

  logic        we8, dn8, ei8, eo8;
  logic [7:0]  addr8;
  logic [31:0] wd8;
  logic [8:0]  cnt8;
  logic        we2, dn2, ei2, eo2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [2:0]  cnt2;

  instr_encoder_loader #(.ADDR_W(8)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_start(st), .i_bus(if8.slave),
    .o_mem_we(we8), .o_mem_addr(addr8), .o_mem_wdata(wd8), .o_word_count(cnt8),
    .o_done(dn8), .o_err_illegal(ei8), .o_err_overflow(eo8)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(st), .i_bus(if2.slave),
    .o_mem_we(we2), .o_mem_addr(addr2), .o_mem_wdata(wd2), .o_word_count(cnt2),
    .o_done(dn2), .o_err_illegal(ei2), .o_err_overflow(eo2)
  );

  int n_vec = 0;
  int n_err = 0;

  bit          m_run  [2];
  bit          m_we   [2];
  bit          m_done [2];
  bit          m_eil  [2];
  bit          m_eov  [2];
  int          m_waddr[2];
  int          m_cnt  [2];
  int          m_addr [2];
  logic [31:0] m_wdata[2];

  logic [31:0] cap8 [256];
  logic [31:0] cap2 [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int o, input int addr);
    logic [15:0] off;
    if (o == 27) return 32'hFC00_0000;
    if (o <= 2) return {6'd0, 5'd0, rt, rd, sh, 6'(FUNC[o])};
    if (o == 6) return {6'd0, rs, 5'd0, 5'd0, 5'd0, 6'd8};
    if (o <= 15) return {6'd0, rs, rt, rd, 5'd0, 6'(FUNC[o])};
    if (o <= 24) begin
      off = imm;
`ifdef ENC_BRANCH_REL_EN
      if (o <= 17) off = 16'(int'(imm) - (addr + 1));
`endif
      return {6'(OPC[o]), rs, rt, off};
    end
    return {6'(OPC[o]), tg};
  endfunction

  task automatic model_step(input int k);
    if (rst) begin
      m_run[k] = 0; m_we[k] = 0; m_done[k] = 0; m_eil[k] = 0; m_eov[k] = 0;
      m_waddr[k] = 0; m_cnt[k] = 0;
    end else begin
      m_we[k] = 0;
      if (!m_run[k]) begin
        if (st) begin
          m_run[k] = 1; m_waddr[k] = 0; m_cnt[k] = 0;
          m_done[k] = 0; m_eil[k] = 0; m_eov[k] = 0;
        end
      end else if (v) begin
        if (int'(op) > 27) m_eil[k] = 1;
        else begin
          m_we[k] = 1;
          m_addr[k] = m_waddr[k];
          m_wdata[k] = enc(int'(op), m_waddr[k]);
          m_cnt[k]++;
          if (op == 5'd27 || m_waddr[k] == DEPTH[k] - 1) begin
            m_run[k] = 0; m_done[k] = 1;
            if (op != 5'd27) m_eov[k] = 1;
          end else m_waddr[k]++;
        end
      end
    end
  endtask

  task automatic cmp(input int k, input logic rdy, input logic we, input int addr,
                     input logic [31:0] wd, input int cnt, input logic dn, input logic ei, input logic eo);
    check($sformatf("dut%0d in_ready", k), 32'(rdy), 32'(m_run[k]));
    check($sformatf("dut%0d mem_we", k), 32'(we), 32'(m_we[k]));
    if (m_we[k]) begin
      check($sformatf("dut%0d mem_addr", k), addr, m_addr[k]);
      check($sformatf("dut%0d mem_wdata", k), wd, m_wdata[k]);
    end
    check($sformatf("dut%0d word_count", k), cnt, m_cnt[k]);
    check($sformatf("dut%0d done", k), 32'(dn), 32'(m_done[k]));
    check($sformatf("dut%0d err_illegal", k), 32'(ei), 32'(m_eil[k]));
    check($sformatf("dut%0d err_overflow", k), 32'(eo), 32'(m_eov[k]));
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    cmp(0, if8.in_ready, we8, int'(addr8), wd8, int'(cnt8), dn8, ei8, eo8);
    cmp(1, if2.in_ready, we2, int'(addr2), wd2, int'(cnt2), dn2, ei2, eo2);
    if (we8 === 1'b1) cap8[addr8] = wd8;
    if (we2 === 1'b1) cap2[addr2] = wd2;
  endtask

  task automatic send(input int o, input int a, input int b, input int c, input int s,
                      input int im, input int t);
    v = 1'b1; op = 5'(o); rs = 5'(a); rt = 5'(b); rd = 5'(c); sh = 5'(s);
    imm = 16'(im); tg = 26'(t);
    tick();
    v = 1'b0;
  endtask

  task automatic do_start();
    for (int i = 0; i < 256; i++) cap8[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) cap2[i] = 32'hDEAD_BEEF;
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; v = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0; sh = '0; imm = '0; tg = '0;
    tick();
    tick();
    check("reset in_ready", 32'(if8.in_ready), 32'd0);
    check("reset mem_addr", 32'(addr8), 32'd0);
    check("reset mem_wdata", wd8, 32'd0);
    rst = 1'b0;
    tick();

    // ADDI / ADD / STOP
    do_start();
    check("in_ready after start", 32'(if8.in_ready), 32'd1);
    send(18, 0, 8, 0, 0, 5, 0);
    send(7, 8, 8, 9, 0, 0, 0);
    send(27, 3, 3, 3, 3, 16'hFFFF, 26'h3FFFFFF);
    check("prog1 w0", cap8[0], 32'h2008_0005);
    check("prog1 w1", cap8[1], 32'h0108_4820);
    check("prog1 w2", cap8[2], 32'hFC00_0000);
    check("prog1 done", 32'(dn8), 32'd1);
    check("prog1 count", 32'(cnt8), 32'd3);
    check("prog1 errs", {30'd0, ei8, eo8}, 32'd0);
    tick();
    check("prog1 ready low", 32'(if8.in_ready), 32'd0);

    // forced fields: SLL with rs supplied, JR with rt/rd supplied
    do_start();
    send(0, 7, 9, 10, 2, 0, 0);
    send(6, 31, 5, 5, 0, 0, 0);
    send(27, 0, 0, 0, 0, 0, 0);
    check("sll forced rs", cap8[0], 32'h0009_5080);
    check("jr forced rt/rd", cap8[1], 32'h03E0_0008);

    // illegal op between ADDUs
    do_start();
    send(8, 1, 2, 3, 0, 0, 0);
    send(29, 1, 2, 3, 0, 0, 0);
    send(8, 1, 2, 3, 0, 0, 0);
    send(27, 0, 0, 0, 0, 0, 0);
    check("illegal flag", 32'(ei8), 32'd1);
    check("addu @0", cap8[0], 32'h0022_1821);
    check("addu @1", cap8[1], 32'h0022_1821);
    check("stop @2", cap8[2], 32'hFC00_0000);
    check("illegal count", 32'(cnt8), 32'd3);

    // overflow on the ADDR_W=2 instance
    do_start();
    for (int i = 0; i < 4; i++) send(23, 0, 1, 0, 0, 4, 0);
    check("ovf w3", cap2[3], 32'h8C01_0004);
    check("ovf flag", 32'(eo2), 32'd1);
    check("ovf done", 32'(dn2), 32'd1);
    check("ovf count", 32'(cnt2), 32'd4);
    tick();
    check("ovf ready low", 32'(if2.in_ready), 32'd0);
    send(27, 0, 0, 0, 0, 0, 0);

    // BEQ as fourth word
    do_start();
    for (int i = 0; i < 3; i++) send(18, 1, 1, 0, 0, i, 0);
    send(16, 1, 2, 0, 0, 0, 0);
    send(27, 0, 0, 0, 0, 0, 0);
`ifdef ENC_BRANCH_REL_EN
    check("beq @3", cap8[3], 32'h1022_FFFC);
`else
    check("beq @3", cap8[3], 32'h1022_0000);
`endif

    // reset right after accepting J
    do_start();
    send(25, 0, 0, 0, 0, 0, 26'h10);
    rst = 1'b1;
    tick();
    check("rst mem_we", 32'(we8), 32'd0);
    check("rst done", 32'(dn8), 32'd0);
    check("rst count", 32'(cnt8), 32'd0);
    check("rst ready", 32'(if8.in_ready), 32'd0);
    check("rst mem_addr", 32'(addr8), 32'd0);
    check("rst mem_wdata", wd8, 32'd0);
    rst = 1'b0;
    tick();
    do_start();
    send(25, 0, 0, 0, 0, 0, 26'h10);
    send(27, 0, 0, 0, 0, 0, 0);
    check("j after reset", cap8[0], 32'h0800_0010);

    // start together with in_valid while idle must not accept
    v = 1'b1; op = 5'd19; st = 1'b1;
    tick();
    st = 1'b0; v = 1'b0;
    check("start+valid count", 32'(cnt8), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      st  = ((!m_run[0] && !m_run[1]) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 19))
        0:       op = 5'($urandom_range(28, 31));
        1, 2:    op = 5'd27;
        default: op = 5'($urandom_range(0, 26));
      endcase
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
      imm = 16'($urandom); tg = 26'($urandom);
      tick();
    end
    rst = 1'b0; st = 1'b0; v = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
